rfifo_fwft: RTL and testbench

RFIFO_FWFT -- requirements
Module: rfifo_fwft

---
 rtl/rfifo_fwft.sv | 80 ++++++++
 tb/tb_rfifo_fwft.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rfifo_fwft.sv
// Purpose: first-word-fall-through adapter from a FIFO read port (rinc/rempty/rdata) to a valid/ready stream.
// Latency: rinc high in cycle T -> word registered at end of T+1 -> m_valid in T+2; no rdata->m_data bypass.
// Backpressure: a 2-entry skid buffer absorbs the in-flight read; rinc stops once buffered + in-flight words reach 2.
//
// Ports:
//   rclk     read-domain clock, all state on its rising edge
//   rrst     synchronous active-high reset
//   rempty   FIFO empty flag (registered on rclk by the pointer stage)
//   rinc     read-increment request to the pointer stage
//   rdata    RAM read data, valid the cycle after rinc
//   m_data   stream data, meaningful only while m_valid=1
//   m_valid  stream valid
//   m_ready  stream ready from the consumer
//   m_count  words currently held in the output buffer (0..2)

module rfifo_fwft #(
  parameter int DSIZE = 8
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             rempty,
  output logic             rinc,
  input  logic [DSIZE-1:0] rdata,
  output logic [DSIZE-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [1:0]       m_count
);

  // Buffer occupancy, the "a read was issued last cycle" flag, and ring pointers.
  logic [1:0]       cnt;
  logic             inflight;
  logic             head;
  logic             tail;
  logic [DSIZE-1:0] buf_q [2];

  logic             pop;
  logic             push;
  logic [2:0]       occ_next;

  assign pop  = m_valid & m_ready;
  // The RAM returns data exactly one cycle after rinc, so a word lands every
  // cycle that follows a read request.
  assign push = inflight;

  // Words that will be owned by this block after this edge, before any new
  // read: buffered + arriving - leaving. Three bits so the sum never wraps;
  // pop implies cnt >= 1, so the subtraction never underflows.
  assign occ_next = {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop};

  // A new read is only issued if its word is guaranteed a slot when it
  // arrives next cycle. Reset gates it combinationally so the pointer stage
  // never advances while both sides are being cleared.
  assign rinc = !rrst && !rempty && (occ_next < 3'd2);

  assign m_valid = (cnt != 2'd0);
  assign m_data  = buf_q[head];
  assign m_count = cnt;

  always_ff @(posedge rclk) begin
    if (rrst) begin
      cnt      <= 2'd0;
      inflight <= 1'b0;
      head     <= 1'b0;
      tail     <= 1'b0;
    end else begin
      inflight <= rinc;
      if (push) tail <= ~tail;
      if (pop)  head <= ~head;
      // Push and pop in the same cycle cancel; occupancy stays put.
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  // Storage is not reset: m_valid=0 after reset masks whatever it holds.
  always_ff @(posedge rclk) begin
    if (!rrst && push) buf_q[tail] <= rdata;
  end

endmodule

// File: tb/tb_rfifo_fwft.sv
// Bench for rfifo_fwft: directed vector table, a streaming run, and a long
// randomized run checked against a queue-based model of the FIFO + stream.

module tb_rfifo_fwft;

  localparam int DSIZE = 8;

  logic             rclk = 1'b0;
  logic             rrst;
  logic             rempty;
  logic             rinc;
  logic [DSIZE-1:0] rdata;
  logic [DSIZE-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic [1:0]       m_count;

  rfifo_fwft #(.DSIZE(DSIZE)) dut (
    .rclk    (rclk),
    .rrst    (rrst),
    .rempty  (rempty),
    .rinc    (rinc),
    .rdata   (rdata),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_count (m_count)
  );

  always #5 rclk = ~rclk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: words still in the FIFO, the word travelling through
  // the RAM read register, and the words the consumer can see, in order.
  logic [7:0] src  [$];
  logic [7:0] outq [$];
  logic       inf_vld = 1'b0;
  logic [7:0] inf_w   = '0;
  logic       stall   = 1'b0;
  logic       prev_rinc = 1'b0;

  // Directed vectors: one record per cycle, outputs observed mid-cycle.
  typedef struct {
    logic       rst;
    logic       rdy;
    int         nload;
    logic [7:0] base;
    logic       chk;
    logic       e_rinc;
    logic       e_valid;
    logic [1:0] e_count;
    logic [7:0] e_data;
  } vec_t;

  vec_t tbl [$];
  vec_t cur;
  logic use_tv = 1'b0;

  // Streaming / random observation.
  logic       collect = 1'b0;
  logic [7:0] obs     [$];
  int         obs_cyc [$];
  int         rinc_hist [$];
  int         dut_beats = 0;
  int         model_beats = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic rdy, input int nload, input logic [7:0] base,
                     input logic c, input logic er, input logic ev, input logic [1:0] ec,
                     input logic [7:0] ed);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.nload = nload; v.base = base; v.chk = c;
    v.e_rinc = er; v.e_valid = ev; v.e_count = ec; v.e_data = ed;
    tbl.push_back(v);
  endtask

  // One clock cycle. Called just after a rising edge with rrst/m_ready/stall
  // already set; checks mid-cycle, then advances the model at the next edge.
  task automatic cycle(input logic c);
    logic e_rinc, e_pop;
    int   occ;
    logic [7:0] tmp;
    rempty = (src.size() == 0) || stall;
    @(negedge rclk);
    e_pop  = (outq.size() != 0) && m_ready;
    occ    = outq.size() + int'(inf_vld) - int'(e_pop);
    e_rinc = !rrst && !rempty && (occ < 2);
    if (c) begin
      chk("rinc", rinc, e_rinc);
      chk("m_valid", m_valid, (outq.size() != 0));
      chk("m_count", m_count, outq.size());
      if (outq.size() != 0) chk("m_data", m_data, outq[0]);
      chk("rinc_while_empty", (rinc && rempty), 0);
      chk("occupancy", (int'(m_count) + int'(prev_rinc) <= 2), 1);
      if (use_tv) begin
        chk("tv_rinc", rinc, cur.e_rinc);
        chk("tv_valid", m_valid, cur.e_valid);
        chk("tv_count", m_count, cur.e_count);
        if (cur.e_valid) chk("tv_data", m_data, cur.e_data);
      end
    end
    if (collect) begin
      rinc_hist.push_back(int'(rinc));
      if (m_valid && m_ready) begin
        obs.push_back(m_data);
        obs_cyc.push_back(cyc);
      end
    end
    if (m_valid && m_ready) dut_beats++;
    if (e_pop) model_beats++;
    prev_rinc = rinc;
    @(posedge rclk);
    #1;
    cyc++;
    if (rrst) begin
      outq.delete();
      src.delete();
      inf_vld = 1'b0;
      rdata = 8'($urandom);
    end else begin
      if (e_pop) tmp = outq.pop_front();
      if (inf_vld) outq.push_back(inf_w);
      if (e_rinc) begin
        inf_w = src.pop_front();
        rdata = inf_w;
      end else begin
        rdata = 8'($urandom);
      end
      inf_vld = e_rinc;
    end
  endtask

  initial begin
    rrst    = 1'b1;
    rempty  = 1'b1;
    m_ready = 1'b0;
    rdata   = '0;

    //   rst rdy nld base  chk rinc val cnt data
    add(1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00);  // 0 power-up, state unknown
    add(1, 1, 0, 8'h00, 1, 0, 0, 0, 8'h00);  // 1 in reset, empty
    add(0, 1, 0, 8'h00, 1, 0, 0, 0, 8'h00);  // 2 release changes nothing
    add(0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00);  // 3
    add(0, 1, 1, 8'hA5, 1, 1, 0, 0, 8'h00);  // 4 single word: rinc in T
    add(0, 1, 0, 8'h00, 1, 0, 0, 0, 8'h00);  // 5 T+1 word in flight
    add(0, 1, 0, 8'h00, 1, 0, 1, 1, 8'hA5);  // 6 T+2 presented
    add(0, 1, 0, 8'h00, 1, 0, 0, 0, 8'h00);  // 7 T+3 gone
    add(0, 0, 3, 8'hB0, 1, 1, 0, 0, 8'h00);  // 8 backpressure fill
    add(0, 0, 0, 8'h00, 1, 1, 0, 0, 8'h00);  // 9
    add(0, 0, 0, 8'h00, 1, 0, 1, 1, 8'hB0);  // 10 cnt+inflight=2 -> stop
    add(0, 0, 0, 8'h00, 1, 0, 1, 2, 8'hB0);  // 11 full
    add(0, 0, 0, 8'h00, 1, 0, 1, 2, 8'hB0);  // 12 data holds
    add(0, 1, 0, 8'h00, 1, 1, 1, 2, 8'hB0);  // 13 pop frees space
    add(0, 1, 0, 8'h00, 1, 0, 1, 1, 8'hB1);  // 14 push+pop
    add(0, 1, 0, 8'h00, 1, 0, 1, 1, 8'hB2);  // 15
    add(0, 1, 0, 8'h00, 1, 0, 0, 0, 8'h00);  // 16
    add(0, 0, 4, 8'hC0, 1, 1, 0, 0, 8'h00);  // 17
    add(0, 0, 0, 8'h00, 1, 1, 0, 0, 8'h00);  // 18
    add(1, 0, 0, 8'h00, 1, 0, 1, 1, 8'hC0);  // 19 reset with cnt=1, inflight=1
    add(0, 1, 0, 8'h00, 1, 0, 0, 0, 8'h00);  // 20 in-flight word discarded
    add(0, 1, 0, 8'h00, 1, 0, 0, 0, 8'h00);  // 21
    add(0, 0, 2, 8'hD0, 1, 1, 0, 0, 8'h00);  // 22
    add(0, 0, 0, 8'h00, 1, 1, 0, 0, 8'h00);  // 23
    add(0, 0, 0, 8'h00, 1, 0, 1, 1, 8'hD0);  // 24
    add(1, 0, 0, 8'h00, 1, 0, 1, 2, 8'hD0);  // 25 reset with cnt=2
    add(0, 1, 0, 8'h00, 1, 0, 0, 0, 8'h00);  // 26 buffer cleared
    add(1, 1, 1, 8'hF0, 1, 0, 0, 0, 8'h00);  // 27 reset gates rinc despite data
    add(0, 1, 0, 8'h00, 1, 0, 0, 0, 8'h00);  // 28

    @(posedge rclk);
    #1;
    use_tv = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      cur     = tbl[i];
      rrst    = cur.rst;
      m_ready = cur.rdy;
      stall   = 1'b0;
      for (int k = 0; k < cur.nload; k++) src.push_back(cur.base + 8'(k));
      cycle(cur.chk);
    end
    use_tv = 1'b0;

    // Streaming: 16 words, never empty, always ready.
    rrst = 1'b0; m_ready = 1'b1; stall = 1'b0;
    for (int k = 0; k < 16; k++) src.push_back(8'(k));
    collect = 1'b1;
    for (int i = 0; i < 20; i++) cycle(1'b1);
    collect = 1'b0;
    for (int i = 0; i < 16; i++) chk("stream_rinc", rinc_hist[i], 1);
    chk("stream_beats", obs.size(), 16);
    if (obs.size() == 16) begin
      for (int i = 0; i < 16; i++) chk("stream_order", obs[i], i);
      chk("stream_no_gap", obs_cyc[15] - obs_cyc[0], 15);
      chk("stream_first_latency", obs_cyc[0] - (cyc - 20), 2);
    end

    // Randomized rempty / m_ready over 10k cycles.
    dut_beats = 0; model_beats = 0;
    for (int i = 0; i < 10000; i++) begin
      if (src.size() < 3 && $urandom_range(0, 3) != 0) src.push_back(8'($urandom));
      stall   = ($urandom_range(0, 3) == 0);
      m_ready = 1'($urandom_range(0, 1));
      cycle(1'b1);
    end
    stall = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 8; i++) cycle(1'b1);
    chk("random_beats", dut_beats, model_beats);
    chk("drain_valid", m_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
